mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor for the PE datapath. Computes (a+b) mod q or (a-b) mod q, selected per operation.
- Two register stages with valid/ready handshake at input and output, so full back-pressure is supported.
- Each operation carries a user tag for channel/lane tracking, plus a running operation counter.
- Successor to the combinational modular adder: width is parametric, subtraction mode is added, and the block is sequential.

Parameters:
- WIDTH, 23, bit width of q, a, b and the result.
- TAG_W, 4, width of the sideband tag passed through unchanged.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block can accept an input this cycle.
- sub_i  in  1  0 = add, 1 = subtract (a-b).
- a_i  in  WIDTH  operand a, must be < q_i.
- b_i  in  WIDTH  operand b, must be < q_i.
- q_i  in  WIDTH  modulus, must be ≥ 2; sampled per operation.
- tag_i  in  TAG_W  sideband tag.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- c_o  out  WIDTH  result in [0, q).
- tag_o  out  TAG_W  tag of the operation on c_o.
- ops_o  out  CNT_W  count of results accepted downstream.

Behaviour:
- Transfer rules:
  - Input transfer occurs when valid_i && ready_o.
  - Output transfer occurs when valid_o && ready_i.
- Stage 1 (registered on input transfer): v1, sub1, q1, tag1, and the raw value r1 (WIDTH+1 bits).
  - Add: r1 = a+b, computed at full WIDTH+1 width so there is no truncation.
  - Sub: r1 = {1'b0,a} - {1'b0,b} in two's complement at WIDTH+1 bits; the MSB is the borrow.
- Stage 2 (correction):
  - Add: if r1 ≥ q1, c = r1 - q1; otherwise c = r1[WIDTH-1:0].
  - Sub: if borrow, c = r1 + q1 truncated to WIDTH bits; otherwise c = r1[WIDTH-1:0].
  - Registers v2, c_o, tag_o.
- Stall logic:
  - en2 = !v2 || ready_i.
  - en1 = !v1 || en2.
  - ready_o = en1. This is combinational from ready_i and the valid bits; there is no combinational path from valid_i.
- When a stage is enabled but its upstream is empty, its valid clears and its data registers hold their value.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to valid_o when ready_i stays high.
  - Throughput is 1 operation per cycle sustained.
- Back-pressure: with ready_i low, the block holds at most 2 operations; ready_o drops once both v1 and v2 are set. c_o and tag_o stay stable while valid_o && !ready_i.
- Simultaneous events: stage 2 full with ready_i high and a new input valid → both stages advance in the same cycle with no bubble.
- ops_o increments by 1 on each output transfer and wraps modulo 2^CNT_W.
- Reset:
  - rst_i high clears v1, v2, c_o, tag_o and ops_o to 0 in the same clock edge.
  - ready_o reads 1 in the cycle after reset releases. ready_o may also read 1 during reset, but inputs are ignored while rst_i is high.
  - Reset mid-operation discards all in-flight operations; no valid_o is produced for them.
- Out-of-range operands (a or b ≥ q) or q < 2: the result is unspecified, but c_o must still be a deterministic WIDTH-bit value and no X may be produced.
- Boundaries that must be exact:
  - a+b = q → 0.
  - a+b = 2q-2 → q-2.
  - a = b → 0 for subtraction.
  - a = 0, b = q-1 → 1 for subtraction.

Test Plan:
- Add wrap, q = 0x7FE001 (8380417): a = 0x7FE000, b = 1, sub = 0 → c_o = 0 exactly 2 cycles later, tag_o = tag_i.
- Add max: same q, a = b = 0x7FE000 → c_o = 0x7FDFFF. Sub borrow: a = 0, b = 1 → c_o = 0x7FE000. Sub equal: a = b = 0x123 → c_o = 0.
- Back-to-back streaming: 100 random ops (a, b < q, random sub and tag), ready_i = 1 → one result per cycle, in order, matching a reference model; ops_o = 100.
- Back-pressure: feed 3 ops with ready_i = 0 → ready_o falls after 2 accepts; c_o and tag_o stay stable. Raise ready_i → results for ops 1, 2, 3 come out in order with no loss or duplication.
- Reset mid-flight: 2 ops accepted, rst_i pulsed for 1 cycle → valid_o = 0, c_o = 0, ops_o = 0, and no stale result appears afterwards.
- Width sweep: WIDTH = 8, q = 255, a = 254, b = 254, add → c_o = 253. Sub with a = 1, b = 254 → c_o = 2.

Source files
------------

// File: rtl/mod_addsub_pipe_if.sv
// Operand/result handshake bundle for mod_addsub_pipe.
interface mod_addsub_pipe_if #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             valid_i;
  logic             ready_o;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] q_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] c_o;
  logic [TAG_W-1:0] tag_o;
  logic [CNT_W-1:0] ops_o;

  modport master (
    output valid_i, sub_i, a_i, b_i, q_i, tag_i, ready_i,
    input  ready_o, valid_o, c_o, tag_o, ops_o
  );

  modport slave (
    input  valid_i, sub_i, a_i, b_i, q_i, tag_i, ready_i,
    output ready_o, valid_o, c_o, tag_o, ops_o
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor with valid/ready back-pressure.
module mod_addsub_pipe #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mod_addsub_pipe_if.slave    bus
);

  logic             v1_q, sub1_q;
  logic [WIDTH:0]   r1_q, r1_d;
  logic [WIDTH-1:0] q1_q;
  logic [TAG_W-1:0] tag1_q;

  logic             v2_q;
  logic [WIDTH-1:0] c_q, c_d;
  logic [TAG_W-1:0] tag2_q;
  logic [CNT_W-1:0] ops_q;

  logic             en1, en2;
  logic [WIDTH:0]   r1_minus_q;

  assign en2 = !v2_q || bus.ready_i;
  assign en1 = !v1_q || en2;

  always_comb begin
    r1_d = '0;
    if (bus.sub_i) r1_d = {1'b0, bus.a_i} - {1'b0, bus.b_i};
    else           r1_d = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  end

  assign r1_minus_q = r1_q - {1'b0, q1_q};

  always_comb begin
    c_d = r1_q[WIDTH-1:0];
    if (sub1_q) begin
      if (r1_q[WIDTH]) c_d = r1_q[WIDTH-1:0] + q1_q;
    end else begin
      if (r1_q >= {1'b0, q1_q}) c_d = r1_minus_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      sub1_q <= 1'b0;
      r1_q   <= '0;
      q1_q   <= '0;
      tag1_q <= '0;
    end else if (en1) begin
      v1_q <= bus.valid_i;
      if (bus.valid_i) begin
        sub1_q <= bus.sub_i;
        r1_q   <= r1_d;
        q1_q   <= bus.q_i;
        tag1_q <= bus.tag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2_q   <= 1'b0;
      c_q    <= '0;
      tag2_q <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        c_q    <= c_d;
        tag2_q <= tag1_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                      ops_q <= '0;
    else if (v2_q && bus.ready_i)   ops_q <= ops_q + CNT_W'(1);
  end

  assign bus.ready_o = en1;
  assign bus.valid_o = v2_q;
  assign bus.c_o     = c_q;
  assign bus.tag_o   = tag2_q;
  assign bus.ops_o   = ops_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Randomised and directed bench for mod_addsub_pipe with a queue-based reference.
module tb_mod_addsub_pipe;
  localparam int unsigned W  = 23;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 16;
  localparam logic [W-1:0] QD = 23'h7FE001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) bus ();
  mod_addsub_pipe_if #(.WIDTH(8), .TAG_W(TW), .CNT_W(CW)) bus8 ();

  mod_addsub_pipe #(.WIDTH(W), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  mod_addsub_pipe #(.WIDTH(8), .TAG_W(TW), .CNT_W(CW)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [W-1:0]  c;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint unsigned ref_mod(input bit sub, input longint unsigned a,
                                              input longint unsigned b, input longint unsigned q);
    if (sub) return (a + q - b) % q;
    else     return (a + b) % q;
  endfunction

  // Scoreboard: transfers are decided at the next rising edge, so look at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
      end else begin
        if (bus.valid_o && bus.ready_i) begin
          check("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb_c", 64'(bus.c_o), 64'(e.c));
            check("sb_tag", 64'(bus.tag_o), 64'(e.tag));
          end
        end
        if (bus.valid_i && bus.ready_o) begin
          e.c   = W'(ref_mod(bus.sub_i, bus.a_i, bus.b_i, bus.q_i));
          e.tag = bus.tag_i;
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [TW-1:0] tag);
    int n = 0;
    bus.sub_i   = sub;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.q_i     = q;
    bus.tag_i   = tag;
    bus.valid_i = 1'b1;
    #1;
    while (!bus.ready_o && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("send_timeout", 64'(n < 50), 64'd1);
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic op_check(input string name, input bit sub, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag,
                          input logic [W-1:0] exp);
    send(sub, a, b, QD, tag);
    check({name, "_lat1"}, 64'(bus.valid_o), 64'd0);
    step();
    check({name, "_valid"}, 64'(bus.valid_o), 64'd1);
    check({name, "_c"}, 64'(bus.c_o), 64'(exp));
    check({name, "_tag"}, 64'(bus.tag_o), 64'(tag));
    step();
  endtask

  initial begin
    logic [W-1:0]  hold_c;
    logic [TW-1:0] hold_t;
    logic [W-1:0]  rq;

    bus.valid_i = 1'b0; bus.sub_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
    bus.q_i = QD; bus.tag_i = '0; bus.ready_i = 1'b1;
    bus8.valid_i = 1'b0; bus8.sub_i = 1'b0; bus8.a_i = '0; bus8.b_i = '0;
    bus8.q_i = 8'd255; bus8.tag_i = '0; bus8.ready_i = 1'b1;

    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_c", 64'(bus.c_o), 64'd0);
    check("rst_tag", 64'(bus.tag_o), 64'd0);
    check("rst_ops", 64'(bus.ops_o), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd1);

    op_check("add_wrap",  1'b0, 23'h7FE000, 23'd1,      4'hA, 23'd0);
    op_check("add_max",   1'b0, 23'h7FE000, 23'h7FE000, 4'h3, 23'h7FDFFF);
    op_check("sub_borrow",1'b1, 23'd0,      23'd1,      4'h5, 23'h7FE000);
    op_check("sub_equal", 1'b1, 23'h123,    23'h123,    4'hC, 23'd0);
    op_check("sub_qm1",   1'b1, 23'd0,      23'h7FE000, 4'h1, 23'd1);
    check("ops_directed", 64'(bus.ops_o), 64'd5);

    rst = 1'b1; step(); rst = 1'b0; step();
    check("rst2_ops", 64'(bus.ops_o), 64'd0);

    // Streaming: one op per cycle, ready_i high throughout.
    bus.ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rq = W'($urandom_range((1 << W) - 1, 2));
      bus.q_i     = rq;
      bus.a_i     = W'($urandom % rq);
      bus.b_i     = W'($urandom % rq);
      bus.sub_i   = 1'($urandom);
      bus.tag_i   = TW'($urandom);
      bus.valid_i = 1'b1;
      #1;
      check("stream_ready", 64'(bus.ready_o), 64'd1);
      step();
    end
    bus.valid_i = 1'b0;
    step();
    check("stream_ops_early", 64'(bus.ops_o), 64'd99);
    step();
    check("stream_ops", 64'(bus.ops_o), 64'd100);
    check("stream_drained", 64'(sbq.size()), 64'd0);

    // Back-pressure: two ops fill the pipe, the third must wait.
    bus.ready_i = 1'b0;
    send(1'b0, 23'd100, 23'd200, QD, 4'h1);
    send(1'b1, 23'd5,   23'd9,   QD, 4'h2);
    bus.sub_i = 1'b0; bus.a_i = 23'h7FE000; bus.b_i = 23'h7FE000;
    bus.q_i = QD; bus.tag_i = 4'h3; bus.valid_i = 1'b1;
    #1;
    check("bp_ready_low", 64'(bus.ready_o), 64'd0);
    check("bp_valid", 64'(bus.valid_o), 64'd1);
    hold_c = bus.c_o;
    hold_t = bus.tag_o;
    check("bp_first_c", 64'(hold_c), 64'd300);
    check("bp_first_tag", 64'(hold_t), 64'd1);
    repeat (3) step();
    check("bp_hold_c", 64'(bus.c_o), 64'(hold_c));
    check("bp_hold_tag", 64'(bus.tag_o), 64'(hold_t));
    check("bp_ops_hold", 64'(bus.ops_o), 64'd100);
    bus.ready_i = 1'b1;
    send(1'b0, 23'h7FE000, 23'h7FE000, QD, 4'h3);
    repeat (4) step();
    check("bp_ops", 64'(bus.ops_o), 64'd103);
    check("bp_drained", 64'(sbq.size()), 64'd0);

    // Reset with two operations in flight.
    bus.ready_i = 1'b0;
    send(1'b0, 23'd1, 23'd2, QD, 4'h7);
    send(1'b0, 23'd3, 23'd4, QD, 4'h8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus.valid_o), 64'd0);
    check("mid_rst_c", 64'(bus.c_o), 64'd0);
    check("mid_rst_ops", 64'(bus.ops_o), 64'd0);
    step();
    check("mid_rst_ready", 64'(bus.ready_o), 64'd1);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_no_stale", 64'(bus.valid_o), 64'd0);
      step();
    end
    check("mid_rst_ops_after", 64'(bus.ops_o), 64'd0);

    // 8-bit instance.
    bus8.ready_i = 1'b1;
    bus8.sub_i = 1'b0; bus8.a_i = 8'd254; bus8.b_i = 8'd254; bus8.q_i = 8'd255;
    bus8.tag_i = 4'h9; bus8.valid_i = 1'b1;
    #1;
    check("w8_ready", 64'(bus8.ready_o), 64'd1);
    step();
    bus8.valid_i = 1'b0;
    step();
    check("w8_add_valid", 64'(bus8.valid_o), 64'd1);
    check("w8_add_c", 64'(bus8.c_o), 64'd253);
    check("w8_add_tag", 64'(bus8.tag_o), 64'd9);
    bus8.sub_i = 1'b1; bus8.a_i = 8'd1; bus8.b_i = 8'd254; bus8.tag_i = 4'h4;
    bus8.valid_i = 1'b1;
    step();
    bus8.valid_i = 1'b0;
    step();
    check("w8_sub_valid", 64'(bus8.valid_o), 64'd1);
    check("w8_sub_c", 64'(bus8.c_o), 64'd2);
    check("w8_sub_tag", 64'(bus8.tag_o), 64'd4);
    step();
    check("w8_ops", 64'(bus8.ops_o), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
